slave_serial_if: RTL and testbench
==================================

// Module: slave_serial_if
// PURPOSE
//  Bus-side front end of a memory slave. Takes serial bus transactions (mode, address, data)
//  from the system bus and deserialises them, so each transaction produces one memory access.
//  Drives the slave memory's wen/ren/addr/wdata ports directly, and serialises read data back onto the bus.
//  Sits between the bus interconnect and the slave memory (directly upstream of the memory).
// PARAMETERS
//  ADDR_WIDTH  16  byte-address width on bus and memory port
//  DATA_WIDTH  32  data word width
// PORTS
//  clk        in   1           single clock, all logic on posedge
//  rst        in   1           synchronous reset, active-high
//  s_valid    in   1           master drives serial transaction; must stay high through addr/data phases
//  s_mode     in   1           sampled at start cycle only: 1=write, 0=read
//  s_wdata    in   1           serial address/write-data bit, LSB first
//  s_ready    out  1           high only in IDLE; start accepted when s_valid & s_ready
//  s_rdata    out  1           serial read-data bit, LSB first
//  s_rvalid   out  1           high while s_rdata carries a valid bit
//  mem_addr   out  ADDR_WIDTH  byte address to memory (memory uses [ADDR_WIDTH-1:2])
//  mem_wdata  out  DATA_WIDTH  write data to memory
//  mem_wen    out  1           one-cycle write strobe
//  mem_ren    out  1           one-cycle read strobe
//  mem_rdata  in   DATA_WIDTH  combinational read data from memory, valid while mem_ren=1
// BEHAVIOUR
//  Reset: state=IDLE; s_ready=1 (first cycle after reset), s_rvalid=0, s_rdata=0, mem_wen=0,
//   mem_ren=0, mem_addr=0, mem_wdata=0, bit counter=0.
//  States: IDLE -> ADDR -> (WDATA -> WRITE | READ -> RDATA) -> IDLE.
//  IDLE: on s_valid=1 at cycle T0, latch mode, go ADDR. s_wdata at T0 is ignored.
//  ADDR: one bit per cycle T1..T(ADDR_WIDTH), shifted into mem_addr LSB first.
//   Last bit -> WDATA if write, else READ.
//  WDATA: DATA_WIDTH bits into mem_wdata, LSB first, then WRITE.
//  WRITE: mem_wen=1 for exactly one cycle (T49 at defaults), then IDLE.
//  READ: mem_ren=1 for exactly one cycle (T17 at defaults); mem_rdata captured in shift reg same edge.
//   s_valid is don't-care from READ onward.
//  RDATA: DATA_WIDTH cycles, s_rvalid=1, s_rdata = captured bit i on i-th cycle (T18..T49 at defaults).
//   Then IDLE, s_ready=1 at T50.
//  Write latency: start to mem_wen = 1+ADDR_WIDTH+DATA_WIDTH cycles. Read turnaround: mem_ren to first bit = 1 cycle.
//  Abort: s_valid=0 in ADDR or WDATA -> IDLE next cycle; no mem_wen/mem_ren; partial mem_addr/mem_wdata
//   may remain but strobes never fire.
//  s_valid high in WRITE/READ/RDATA: ignored; new start is accepted only from IDLE (back-to-back allowed
//   on the cycle s_ready=1).
//  Reset mid-operation wins over everything: IDLE next cycle, strobes low, s_rvalid low.
//  mem_wen and mem_ren are never high together; each lasts exactly one cycle.
//  Bit counter: $clog2(max(ADDR_WIDTH,DATA_WIDTH)) bits, cleared on every state entry, no wrap beyond phase length.
//  Address is passed unchecked; range decoding belongs to the interconnect.
// STRUCTURE
//  Shared package bus_pkg: state encoding localparams (IDLE, ADDR, WDATA, WRITE, READ, RDATA),
//   MODE_WRITE/MODE_READ constants, default ADDR_WIDTH/DATA_WIDTH.
//  One natural sub-module: serial_shift_reg (parameterised width; parallel load, shift-in, shift-out LSB first).
//   Instantiated for addr, wdata and rdata paths.
//  FSM and counter stay in this module.
// TESTING
//  Write: start mode=1, addr=0x0010, data=0xDEADBEEF -> mem_wen=1 at T49 only, mem_addr=0x0010,
//   mem_wdata=0xDEADBEEF.
//  Read: memory word at 0x0010 = 0xDEADBEEF, start mode=0 -> mem_ren at T17, s_rvalid T18..T49,
//   serial stream = 0xDEADBEEF LSB first.
//  Abort: drop s_valid after 8 addr bits -> IDLE next cycle, s_ready=1, no strobe ever.
//  Back-to-back: write 0x0004 <- 0x12345678 then read 0x0004 starting the cycle s_ready returns
//   -> reads back 0x12345678.
//  Reset mid-RDATA (bit 10) -> next cycle s_rvalid=0, s_ready=1, all outputs at reset values.
//  s_valid held high during RDATA -> ignored; no second mem_ren until after IDLE.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the serial slave bus front end.
package bus_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    READ,
    RDATA
  } state_t;

  // Bit-counter width: enough to count the longer of the address and data phases.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Serial shift register: parallel load, shift-in at MSB, so data arrives LSB first
// and leaves LSB first from q[0].
module serial_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic [WIDTH-1:0] q
);

  // Load has priority over shift; both are ignored while in reset.
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (load)
      q <= load_data;
    else if (shift_en)
      q <= {shift_in, q[WIDTH-1:1]};
  end

endmodule

// File: rtl/slave_serial_if.sv
// Bus-side serial front end of a memory slave: deserialises mode/address/data,
// issues one memory strobe per transaction and serialises read data back.
module slave_serial_if
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic                  s_mode,
  input  logic                  s_wdata,
  output logic                  s_ready,
  output logic                  s_rdata,
  output logic                  s_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CW = cnt_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  state_t                state, state_next;
  logic [CW-1:0]         cnt;
  logic                  mode;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  unused_rdata_hi;

  // Only q[0] of the read path leaves the block; upper bits just feed the shift chain.
  assign unused_rdata_hi = ^rdata_q[DATA_WIDTH-1:1];

  serial_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  ((state == ADDR) && s_valid),
    .shift_in  (s_wdata),
    .q         (mem_addr)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_wdata_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  ((state == WDATA) && s_valid),
    .shift_in  (s_wdata),
    .q         (mem_wdata)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_rdata_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (state == READ),
    .load_data (mem_rdata),
    .shift_en  (state == RDATA),
    .shift_in  (1'b0),
    .q         (rdata_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Transaction mode, captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst)
      mode <= MODE_READ;
    else if ((state == IDLE) && s_valid)
      mode <= s_mode;
  end

  // Bit counter: cleared on every state change, counts only inside serial phases.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (state_next != state)
      cnt <= '0;
    else if ((state == ADDR) || (state == WDATA) || (state == RDATA))
      cnt <= cnt + 1'b1;
  end

  // Next-state and strobe/handshake decode.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    s_rvalid   = 1'b0;
    s_rdata    = 1'b0;
    mem_wen    = 1'b0;
    mem_ren    = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid)
          state_next = ADDR;
      end
      ADDR: begin
        if (!s_valid)
          state_next = IDLE;
        else if (cnt == ADDR_LAST)
          state_next = (mode == MODE_WRITE) ? WDATA : READ;
      end
      WDATA: begin
        if (!s_valid)
          state_next = IDLE;
        else if (cnt == DATA_LAST)
          state_next = WRITE;
      end
      WRITE: begin
        mem_wen    = 1'b1;
        state_next = IDLE;
      end
      READ: begin
        mem_ren    = 1'b1;
        state_next = RDATA;
      end
      RDATA: begin
        s_rvalid = 1'b1;
        s_rdata  = rdata_q[0];
        if (cnt == DATA_LAST)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_slave_serial_if.sv
// Directed bench for slave_serial_if with a small behavioural memory.
module tb_slave_serial_if;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_mode, s_wdata;
  logic          s_ready, s_rdata, s_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen, mem_ren;
  logic [DW-1:0] mem_rdata;

  slave_serial_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_mode    (s_mode),
    .s_wdata   (s_wdata),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .s_rvalid  (s_rvalid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // 16-word memory indexed by word address bits [5:2]
  logic [DW-1:0] mem [0:15];
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_wen) mem[mem_addr[5:2]] <= mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  // per-transaction monitor
  int          tcyc, wen_cnt, ren_cnt, wen_at, ren_at, rv_first, rv_last, rcnt, both_cnt, ready_at;
  logic [15:0] wen_addr, ren_addr;
  logic [31:0] wen_data, rword;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          hold;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr_mon();
    tcyc = 0; wen_cnt = 0; ren_cnt = 0; wen_at = -1; ren_at = -1;
    rv_first = -1; rv_last = -1; rcnt = 0; both_cnt = 0; ready_at = -1;
    wen_addr = '0; ren_addr = '0; wen_data = '0; rword = '0;
  endtask

  task automatic mon();
    if (mem_wen) begin wen_cnt++; wen_at = tcyc; wen_addr = mem_addr; wen_data = mem_wdata; end
    if (mem_ren) begin ren_cnt++; ren_at = tcyc; ren_addr = mem_addr; end
    if (mem_wen && mem_ren) both_cnt++;
    if (s_rvalid) begin
      if (rcnt < 32) rword[rcnt] = s_rdata;
      if (rv_first < 0) rv_first = tcyc;
      rv_last = tcyc;
      rcnt++;
    end
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
    tcyc++;
  endtask

  task automatic smp();
    @(negedge clk);
    mon();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cyc(); s_valid = 1'b0; smp();
    end
  endtask

  // Called at a negedge; T0 is the current cycle.
  task automatic send_hdr(input bit wr, input logic [15:0] a);
    clr_mon();
    chk("start_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1; s_mode = wr; s_wdata = 1'b1;
    mon();
    for (int i = 0; i < 16; i++) begin
      next_cyc(); s_wdata = a[i]; s_mode = ~wr; smp();
      if (i == 0) chk("busy_ready", 32'(s_ready), 32'd0);
    end
  endtask

  task automatic send_data(input logic [31:0] d);
    for (int i = 0; i < 32; i++) begin
      next_cyc(); s_wdata = d[i]; smp();
    end
  endtask

  task automatic finish_txn(input bit hold);
    for (int k = 0; k < 64 && ready_at < 0; k++) begin
      next_cyc(); s_valid = hold && (tcyc <= 49); s_wdata = 1'b0; smp();
      if (s_ready) ready_at = tcyc;
    end
    s_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    send_hdr(v.wr, v.addr);
    if (v.wr) send_data(v.data);
    finish_txn(v.hold);
    chk($sformatf("v%0d_ready_at", idx), 32'(ready_at), 32'd50);
    chk($sformatf("v%0d_both", idx), 32'(both_cnt), 32'd0);
    if (v.wr) begin
      chk($sformatf("v%0d_wen_cnt", idx), 32'(wen_cnt), 32'd1);
      chk($sformatf("v%0d_wen_at", idx), 32'(wen_at), 32'd49);
      chk($sformatf("v%0d_ren_cnt", idx), 32'(ren_cnt), 32'd0);
      chk($sformatf("v%0d_wen_addr", idx), 32'(wen_addr), 32'(v.addr));
      chk($sformatf("v%0d_wen_data", idx), wen_data, v.data);
    end else begin
      chk($sformatf("v%0d_ren_cnt", idx), 32'(ren_cnt), 32'd1);
      chk($sformatf("v%0d_ren_at", idx), 32'(ren_at), 32'd17);
      chk($sformatf("v%0d_wen_cnt", idx), 32'(wen_cnt), 32'd0);
      chk($sformatf("v%0d_ren_addr", idx), 32'(ren_addr), 32'(v.addr));
      chk($sformatf("v%0d_rbits", idx), 32'(rcnt), 32'd32);
      chk($sformatf("v%0d_rv_first", idx), 32'(rv_first), 32'd18);
      chk($sformatf("v%0d_rv_last", idx), 32'(rv_last), 32'd49);
      chk($sformatf("v%0d_rword", idx), rword, v.exp_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] part;
    vecs[0] = '{wr: 1'b1, addr: 16'h0010, data: 32'hDEADBEEF, exp_rd: 32'h0,        hold: 1'b0};
    vecs[1] = '{wr: 1'b0, addr: 16'h0010, data: 32'h0,        exp_rd: 32'hDEADBEEF, hold: 1'b0};
    vecs[2] = '{wr: 1'b1, addr: 16'h003C, data: 32'hA5A50F0F, exp_rd: 32'h0,        hold: 1'b0};
    vecs[3] = '{wr: 1'b0, addr: 16'h003C, data: 32'h0,        exp_rd: 32'hA5A50F0F, hold: 1'b1};
    vecs[4] = '{wr: 1'b1, addr: 16'h0000, data: 32'hFFFFFFFF, exp_rd: 32'h0,        hold: 1'b0};
    vecs[5] = '{wr: 1'b0, addr: 16'h0000, data: 32'h0,        exp_rd: 32'hFFFFFFFF, hold: 1'b1};
    vecs[6] = '{wr: 1'b0, addr: 16'hFFF0, data: 32'h0,        exp_rd: 32'h00000000, hold: 1'b0};
    vecs[7] = '{wr: 1'b1, addr: 16'h8001, data: 32'h00000001, exp_rd: 32'h0,        hold: 1'b0};
    vecs[8] = '{wr: 1'b0, addr: 16'h0000, data: 32'h0,        exp_rd: 32'h00000001, hold: 1'b0};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    clr_mon();
    rst = 1'b1; s_valid = 1'b0; s_mode = 1'b0; s_wdata = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    chk("rst_ready",  32'(s_ready),  32'd1);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_rdata",  32'(s_rdata),  32'd0);
    chk("rst_wen",    32'(mem_wen),  32'd0);
    chk("rst_ren",    32'(mem_ren),  32'd0);
    chk("rst_addr",   32'(mem_addr), 32'd0);
    chk("rst_wdata",  mem_wdata,     32'd0);

    for (int i = 0; i < 9; i++) begin
      idle(2);
      run_vec(i, vecs[i]);
    end

    // back-to-back: read starts in the very cycle s_ready returns after the write
    idle(2);
    run_vec(20, '{wr: 1'b1, addr: 16'h0004, data: 32'h12345678, exp_rd: 32'h0, hold: 1'b0});
    run_vec(21, '{wr: 1'b0, addr: 16'h0004, data: 32'h0, exp_rd: 32'h12345678, hold: 1'b0});

    // abort after 8 address bits
    idle(2);
    clr_mon();
    s_valid = 1'b1; s_mode = 1'b1; s_wdata = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next_cyc(); s_wdata = i[0]; smp();
    end
    next_cyc(); s_valid = 1'b0; smp();
    chk("abort_busy", 32'(s_ready), 32'd0);
    next_cyc(); smp();
    chk("abort_ready", 32'(s_ready), 32'd1);
    idle(60);
    chk("abort_wen", 32'(wen_cnt), 32'd0);
    chk("abort_ren", 32'(ren_cnt), 32'd0);

    // reset while bit 10 of read data is on the bus
    idle(2);
    send_hdr(1'b0, 16'h0010);
    for (int k = 0; k < 40 && rcnt < 10; k++) begin
      next_cyc(); s_valid = 1'b0; smp();
    end
    chk("rstmid_bits", 32'(rcnt), 32'd10);
    part = 32'hDEADBEEF & 32'h000003FF;
    chk("rstmid_partial", rword, part);
    next_cyc(); rst = 1'b1; smp();
    chk("rstmid_bit10", 32'(s_rdata), 32'd1);
    next_cyc(); rst = 1'b0; smp();
    chk("rstmid_rvalid", 32'(s_rvalid), 32'd0);
    chk("rstmid_ready",  32'(s_ready),  32'd1);
    chk("rstmid_rdata",  32'(s_rdata),  32'd0);
    chk("rstmid_wen",    32'(mem_wen),  32'd0);
    chk("rstmid_ren",    32'(mem_ren),  32'd0);
    chk("rstmid_addr",   32'(mem_addr), 32'd0);
    chk("rstmid_wdata",  mem_wdata,     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
